// File: rtl/sobel_edge_filter.sv
// Three-stage Sobel edge detector on a 3x3 RGB888 window: grayscale, gradients, magnitude/flag.
// Data-enable, coordinates and a border flag travel alongside the data so outputs stay aligned.
module sobel_edge_filter #(
  parameter int WIDTH    = 24,
  parameter int H_ACTIVE = 1920,
  parameter int V_ACTIVE = 1080
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             de_in,
  input  logic [10:0]      x_pixel,
  input  logic [10:0]      y_pixel,
  input  logic [WIDTH-1:0] PixelData_00,
  input  logic [WIDTH-1:0] PixelData_01,
  input  logic [WIDTH-1:0] PixelData_02,
  input  logic [WIDTH-1:0] PixelData_10,
  input  logic [WIDTH-1:0] PixelData_11,
  input  logic [WIDTH-1:0] PixelData_12,
  input  logic [WIDTH-1:0] PixelData_20,
  input  logic [WIDTH-1:0] PixelData_21,
  input  logic [WIDTH-1:0] PixelData_22,
  input  logic [7:0]       threshold,
  output logic             de_out,
  output logic [10:0]      x_out,
  output logic [10:0]      y_out,
  output logic [7:0]       edge_mag,
  output logic             edge_bit
);

  // Luma weights sum to 256, so the top byte of the 16-bit sum is the gray level.
  function automatic logic [7:0] to_gray(input logic [WIDTH-1:0] p);
    logic [15:0] s;
    s = 16'd77  * {8'd0, p[23:16]}
      + 16'd150 * {8'd0, p[15:8]}
      + 16'd29  * {8'd0, p[7:0]};
    return s[15:8];
  endfunction

  function automatic logic signed [10:0] ext1(input logic [7:0] g);
    return $signed({3'b000, g});
  endfunction

  function automatic logic signed [10:0] ext2(input logic [7:0] g);
    return $signed({2'b00, g, 1'b0});
  endfunction

  logic [WIDTH-1:0] tap [9];

  // Stage 1 state
  logic [7:0]  gray_d [9];
  logic [7:0]  gray_q [9];
  logic        de1_d, de1_q;
  logic [10:0] x1_d, x1_q;
  logic [10:0] y1_d, y1_q;
  logic        border1_d, border1_q;

  // Stage 2 state
  logic signed [10:0] gx_d, gx_q;
  logic signed [10:0] gy_d, gy_q;
  logic               de2_d, de2_q;
  logic [10:0]        x2_d, x2_q;
  logic [10:0]        y2_d, y2_q;
  logic               border2_d, border2_q;

  // Stage 3 state (drives the outputs directly)
  logic        de3_d, de3_q;
  logic [10:0] x3_d, x3_q;
  logic [10:0] y3_d, y3_q;
  logic [7:0]  mag3_d, mag3_q;
  logic        bit3_d, bit3_q;

  logic [10:0] abs_gx;
  logic [10:0] abs_gy;
  logic [10:0] grad_sum;

  always_comb begin
    tap[0] = PixelData_00;
    tap[1] = PixelData_01;
    tap[2] = PixelData_02;
    tap[3] = PixelData_10;
    tap[4] = PixelData_11;
    tap[5] = PixelData_12;
    tap[6] = PixelData_20;
    tap[7] = PixelData_21;
    tap[8] = PixelData_22;

    for (int unsigned i = 0; i < 9; i++) begin
      gray_d[i] = to_gray(tap[i]);
    end
    de1_d     = de_in;
    x1_d      = x_pixel;
    y1_d      = y_pixel;
    border1_d = (x_pixel == 11'd0) || (x_pixel == 11'(H_ACTIVE - 1)) ||
                (y_pixel == 11'd0) || (y_pixel == 11'(V_ACTIVE - 1));

    // gray_q index = row*3 + col
    gx_d = (ext1(gray_q[2]) + ext2(gray_q[5]) + ext1(gray_q[8]))
         - (ext1(gray_q[0]) + ext2(gray_q[3]) + ext1(gray_q[6]));
    gy_d = (ext1(gray_q[6]) + ext2(gray_q[7]) + ext1(gray_q[8]))
         - (ext1(gray_q[0]) + ext2(gray_q[1]) + ext1(gray_q[2]));
    de2_d     = de1_q;
    x2_d      = x1_q;
    y2_d      = y1_q;
    border2_d = border1_q;

    abs_gx   = gx_q[10] ? 11'(-gx_q) : 11'(gx_q);
    abs_gy   = gy_q[10] ? 11'(-gy_q) : 11'(gy_q);
    grad_sum = abs_gx + abs_gy;

    mag3_d = (grad_sum > 11'd255) ? 8'hFF : grad_sum[7:0];
    if (!de2_q || border2_q) begin
      mag3_d = '0;
    end
    bit3_d = (mag3_d > threshold);
    de3_d  = de2_q;
    x3_d   = x2_q;
    y3_d   = y2_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 9; i++) begin
        gray_q[i] <= '0;
      end
      de1_q     <= 1'b0;
      x1_q      <= '0;
      y1_q      <= '0;
      border1_q <= 1'b0;
      gx_q      <= '0;
      gy_q      <= '0;
      de2_q     <= 1'b0;
      x2_q      <= '0;
      y2_q      <= '0;
      border2_q <= 1'b0;
      de3_q     <= 1'b0;
      x3_q      <= '0;
      y3_q      <= '0;
      mag3_q    <= '0;
      bit3_q    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 9; i++) begin
        gray_q[i] <= gray_d[i];
      end
      de1_q     <= de1_d;
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      border1_q <= border1_d;
      gx_q      <= gx_d;
      gy_q      <= gy_d;
      de2_q     <= de2_d;
      x2_q      <= x2_d;
      y2_q      <= y2_d;
      border2_q <= border2_d;
      de3_q     <= de3_d;
      x3_q      <= x3_d;
      y3_q      <= y3_d;
      mag3_q    <= mag3_d;
      bit3_q    <= bit3_d;
    end
  end

  assign de_out   = de3_q;
  assign x_out    = x3_q;
  assign y_out    = y3_q;
  assign edge_mag = mag3_q;
  assign edge_bit = bit3_q;

endmodule
